puf_auth_verifier: RTL and testbench

// - Server/verifier end of the PUF challenge-response authentication protocol.
// - Holds an enrolled CRP table (challenge -> expected 8-bit response) and issues

---
 rtl/puf_auth_pkg.sv | 29 ++
 rtl/crp_table.sv | 27 ++
 rtl/puf_auth_verifier.sv | 156 +++++++++++++++
 tb/tb_puf_auth_verifier.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_auth_pkg.sv
// Shared constants, state encoding and helpers for the PUF authentication verifier.
// The LFSR polynomial is x^8+x^6+x^5+x^4+1, realised as a left-shifting Fibonacci register.
package puf_auth_pkg;

    localparam int W   = 8;
    localparam int PCW = $clog2(W + 1);

    // Taps on bits 7,5,4,3 are the x^8, x^6, x^5 and x^4 terms; feedback enters bit 0.
    localparam logic [W-1:0] LFSR_TAPS  = 8'hB8;
    localparam logic [W-1:0] LFSR_RESET = 8'h01;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_e;

    function automatic logic [PCW-1:0] popcount(input logic [W-1:0] v);
        logic [PCW-1:0] n;
        n = '0;
        for (int i = 0; i < W; i++) begin
            n = n + {{(PCW-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/crp_table.sv
// Enrolled challenge-response table: synchronous write, combinational read.
// Contents are deliberately not reset so enrollment survives a protocol abort.
module crp_table
    import puf_auth_pkg::*;
#(
    parameter int AW = W,
    parameter int DW = W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/puf_auth_verifier.sv
// Verifier side of the PUF challenge-response protocol: issues LFSR challenges,
// scores returned responses by Hamming distance and reports a pass/fail verdict.
module puf_auth_verifier
    import puf_auth_pkg::*;
#(
    parameter int ROUNDS   = 16,
    parameter int HD_MAX   = 1,
    parameter int FAIL_MAX = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enroll_we,
    input  logic [W-1:0] enroll_chal,
    input  logic [W-1:0] enroll_resp,
    input  logic         start,
    input  logic [W-1:0] seed,
    output logic         chal_valid,
    input  logic         chal_ready,
    output logic [W-1:0] chal_data,
    input  logic         resp_valid,
    input  logic [W-1:0] resp_data,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [4:0]   fail_cnt
);

    localparam int RW = $clog2(ROUNDS + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [4:0] FAIL_SAT = 5'd31;

    state_e         state_q, state_d;
    logic [W-1:0]   lfsr_q, lfsr_d;
    logic [RW-1:0]  round_q, round_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [4:0]     fail_q, fail_d;
    logic           pass_q, pass_d;
    logic [W-1:0]   exp_q, exp_d;
    logic [W-1:0]   resp_q, resp_d;
    logic           tout_q, tout_d;

    logic           busy_int;
    logic [W-1:0]   table_rdata;
    logic [W-1:0]   lfsr_step;
    logic [PCW-1:0] hd;

    assign busy_int  = (state_q == ISSUE) || (state_q == WAIT) || (state_q == CHECK);
    assign lfsr_step = {lfsr_q[W-2:0], ^(lfsr_q & LFSR_TAPS)};
    assign hd        = popcount(resp_q ^ exp_q);

    // The challenge address is the live LFSR, so the golden response is ready on the transfer cycle.
    crp_table u_table (
        .clk   (clk),
        .we    (enroll_we && !busy_int),
        .waddr (enroll_chal),
        .wdata (enroll_resp),
        .raddr (lfsr_q),
        .rdata (table_rdata)
    );

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        round_d = round_q;
        timer_d = timer_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        exp_d   = exp_q;
        resp_d  = resp_q;
        tout_d  = tout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    lfsr_d  = (seed == '0) ? LFSR_RESET : seed;
                    fail_d  = '0;
                    round_d = '0;
                    pass_d  = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (chal_ready) begin
                    exp_d   = table_rdata;
                    lfsr_d  = lfsr_step;
                    timer_d = '0;
                    tout_d  = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A response arriving on the last timer cycle still counts as a response.
                if (resp_valid) begin
                    resp_d  = resp_data;
                    state_d = CHECK;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    tout_d  = 1'b1;
                    state_d = CHECK;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CHECK: begin
                if ((tout_q || (int'(hd) > HD_MAX)) && (fail_q != FAIL_SAT)) begin
                    fail_d = fail_q + 1'b1;
                end
                round_d = round_q + 1'b1;
                if (round_d == RW'(ROUNDS)) begin
                    pass_d  = (int'(fail_d) <= FAIL_MAX);
                    state_d = DONE;
                end else begin
                    state_d = ISSUE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_RESET;
            round_q <= '0;
            timer_q <= '0;
            fail_q  <= '0;
            pass_q  <= 1'b0;
            exp_q   <= '0;
            resp_q  <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            round_q <= round_d;
            timer_q <= timer_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
            exp_q   <= exp_d;
            resp_q  <= resp_d;
            tout_q  <= tout_d;
        end
    end

    assign chal_valid = (state_q == ISSUE);
    assign chal_data  = (state_q == ISSUE) ? lfsr_q : '0;
    assign busy       = busy_int;
    assign done       = (state_q == DONE);
    assign pass       = pass_q;
    assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_puf_auth_verifier.sv
// Self-checking bench for puf_auth_verifier: a device model plus a protocol-level
// reference that predicts challenges, verdicts and latency for each directed run.
module tb_puf_auth_verifier;

    localparam int ROUNDS   = 16;
    localparam int FAIL_MAX = 2;
    localparam int TIMEOUT  = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enroll_we;
    logic [7:0] enroll_chal;
    logic [7:0] enroll_resp;
    logic       start;
    logic [7:0] seed;
    logic       chal_valid;
    logic       chal_ready;
    logic [7:0] chal_data;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] fail_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Run configuration and reference expectations, owned by the main process.
    bit         dev_respond = 1'b1;
    int         hold_req    = 0;
    int         run_id      = 0;
    int         start_cyc   = 0;
    logic [7:0] flip_mask [ROUNDS];
    logic [7:0] exp_chal  [ROUNDS];
    logic [7:0] prev_seq  [ROUNDS];
    int         exp_fail;
    bit         exp_pass;
    int         exp_lat;

    // Observations, owned by the device/compare process.
    int         seen_run  = 0;
    int         xfer_idx  = 0;
    int         done_seen = 0;
    int         stall_cnt = 0;
    bit         pending   = 1'b0;
    logic [7:0] pend_chal;
    int         pend_round;
    logic [7:0] act_chal  [ROUNDS];

    puf_auth_verifier dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enroll_we   (enroll_we),
        .enroll_chal (enroll_chal),
        .enroll_resp (enroll_resp),
        .start       (start),
        .seed        (seed),
        .chal_valid  (chal_valid),
        .chal_ready  (chal_ready),
        .chal_data   (chal_data),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .fail_cnt    (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Polynomial x^8+x^6+x^5+x^4+1: the incoming bit is s8^s6^s5^s4 where s_k is v[k-1].
    function automatic logic [7:0] nextChallenge(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    task automatic buildModel(input logic [7:0] s);
        logic [7:0] v;
        int f;
        int per_round;
        v = (s == 8'h00) ? 8'h01 : s;
        f = 0;
        for (int r = 0; r < ROUNDS; r++) begin
            exp_chal[r] = v;
            v = nextChallenge(v);
            if (!dev_respond || ($countones(flip_mask[r]) > 1)) f++;
        end
        exp_fail  = (f > 31) ? 31 : f;
        exp_pass  = (exp_fail <= FAIL_MAX);
        per_round = 1 + (dev_respond ? 1 : TIMEOUT) + 1;
        exp_lat   = 1 + ROUNDS * per_round + (dev_respond ? hold_req : 0) + 1;
    endtask

    // Device model and compare process: checks every offered challenge and every verdict.
    initial begin
        chal_ready = 1'b1;
        resp_valid = 1'b0;
        resp_data  = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pending    = 1'b0;
                resp_valid = 1'b0;
                chal_ready = 1'b1;
            end else begin
                if (run_id != seen_run) begin
                    seen_run  = run_id;
                    xfer_idx  = 0;
                    done_seen = 0;
                    stall_cnt = 0;
                end
                if (chal_valid) begin
                    if (xfer_idx < ROUNDS) begin
                        checkOutput("chal_data", {24'h0, chal_data}, {24'h0, exp_chal[xfer_idx]});
                    end else begin
                        n_cmp++;
                        n_bad++;
                        $display("[TB] FAIL extra_round: got round %0d, expected at most %0d", xfer_idx, ROUNDS - 1);
                    end
                end
                if (done) begin
                    done_seen++;
                    checkOutput("fail_cnt", {27'h0, fail_cnt}, exp_fail);
                    checkOutput("pass", {31'h0, pass}, {31'h0, exp_pass});
                    checkOutput("latency", cyc - start_cyc, exp_lat);
                end
                resp_valid = 1'b0;
                if (pending && dev_respond) begin
                    resp_valid = 1'b1;
                    resp_data  = pend_chal ^ 8'h5A ^ flip_mask[pend_round];
                end
                pending    = 1'b0;
                chal_ready = 1'b1;
                if (chal_valid && xfer_idx == 0 && stall_cnt < hold_req) begin
                    chal_ready = 1'b0;
                    stall_cnt++;
                end
                if (chal_valid && chal_ready) begin
                    pending    = 1'b1;
                    pend_chal  = chal_data;
                    pend_round = xfer_idx;
                    if (xfer_idx < ROUNDS) act_chal[xfer_idx] = chal_data;
                    xfer_idx++;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] s, input bit corrupt, input bit restart, input bit fix_first);
        buildModel(s);
        run_id++;
        if (fix_first) begin
            @(posedge clk); #2;
            enroll_we   = 1'b1;
            enroll_chal = exp_chal[0];
            enroll_resp = exp_chal[0] ^ 8'hA5;
        end
        @(posedge clk); #2;
        start     = 1'b1;
        seed      = s;
        start_cyc = cyc;
        enroll_we = 1'b0;
        if (fix_first) begin
            enroll_we   = 1'b1;
            enroll_chal = exp_chal[0];
            enroll_resp = exp_chal[0] ^ 8'h5A;
        end
        for (int k = 0; k < 3000 && done_seen == 0; k++) begin
            @(posedge clk); #2;
            start     = 1'b0;
            enroll_we = 1'b0;
            if (corrupt && k < ROUNDS) begin
                enroll_we   = 1'b1;
                enroll_chal = exp_chal[k];
                enroll_resp = ~(exp_chal[k] ^ 8'h5A);
            end
            if (restart && k == 10) begin
                start = 1'b1;
                seed  = ~s;
            end
        end
        start     = 1'b0;
        enroll_we = 1'b0;
        checkOutput("done_seen", done_seen, 1);
        checkOutput("rounds", xfer_idx, ROUNDS);
        @(posedge clk); #2;
        checkOutput("pass_held", {31'h0, pass}, {31'h0, exp_pass});
        checkOutput("busy_after", {31'h0, busy}, 0);
    endtask

    task automatic setFlips(input int mode);
        for (int r = 0; r < ROUNDS; r++) begin
            case (mode)
                1:       flip_mask[r] = 8'(1 << (r % 8));
                2:       flip_mask[r] = (r == 2 || r == 7 || r == 11) ? 8'h03 : 8'h00;
                3:       flip_mask[r] = (r == 4) ? 8'h81 : ((r == 9) ? 8'h18 : 8'h00);
                default: flip_mask[r] = 8'h00;
            endcase
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no completion, expected summary before 2ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        enroll_we   = 1'b0;
        enroll_chal = 8'h00;
        enroll_resp = 8'h00;
        start       = 1'b0;
        seed        = 8'h00;
        setFlips(0);

        #23;
        checkOutput("reset_outputs", {15'h0, chal_valid, busy, done, pass, chal_data, fail_cnt}, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        for (int c = 0; c < 256; c++) begin
            @(posedge clk); #2;
            enroll_we   = 1'b1;
            enroll_chal = 8'(c);
            enroll_resp = 8'(c) ^ 8'h5A;
        end
        @(posedge clk); #2;
        enroll_we = 1'b0;

        // Hand-derived pins for the reference model.
        buildModel(8'h01);
        checkOutput("model_seq1", {exp_chal[1], exp_chal[2], exp_chal[3], exp_chal[4]}, 32'h02040811);
        checkOutput("model_lat", exp_lat, 50);

        // Clean run; an enroll write coinciding with start repairs the first entry in time.
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1);
        for (int r = 0; r < ROUNDS; r++) prev_seq[r] = act_chal[r];

        // One flipped bit per round, with an ignored start mid-run; same seed as before.
        setFlips(1);
        applyStimulus(8'h3C, 1'b0, 1'b1, 1'b0);
        for (int r = 0; r < ROUNDS; r++) checkOutput("same_seed_seq", {24'h0, act_chal[r]}, {24'h0, prev_seq[r]});

        setFlips(2);
        buildModel(8'h77);
        checkOutput("model_fail_hd2", exp_fail, 3);
        checkOutput("model_pass_hd2", {31'h0, exp_pass}, 0);
        applyStimulus(8'h77, 1'b0, 1'b0, 1'b0);

        setFlips(3);
        applyStimulus(8'hC3, 1'b0, 1'b0, 1'b0);

        setFlips(0);
        dev_respond = 1'b0;
        buildModel(8'h10);
        checkOutput("model_lat_timeout", exp_lat, 1058);
        applyStimulus(8'h10, 1'b0, 1'b0, 1'b0);
        dev_respond = 1'b1;

        hold_req = 10;
        applyStimulus(8'hA1, 1'b0, 1'b0, 1'b0);
        checkOutput("stall_cycles", stall_cnt, 10);
        hold_req = 0;

        buildModel(8'h00);
        checkOutput("model_seed0", {24'h0, exp_chal[0]}, 32'h01);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);

        // Abort during the wait phase of round 5, then rerun from round 0.
        buildModel(8'h5E);
        run_id++;
        @(posedge clk); #2;
        start     = 1'b1;
        seed      = 8'h5E;
        start_cyc = cyc;
        @(posedge clk); #2;
        start = 1'b0;
        for (int k = 0; k < 500 && xfer_idx < 6; k++) begin
            @(posedge clk); #1;
        end
        checkOutput("reached_round5", xfer_idx, 6);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_outputs", {15'h0, chal_valid, busy, done, pass, chal_data, fail_cnt}, 0);
        checkOutput("abort_no_done", done_seen, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        applyStimulus(8'h5E, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
